// File: rtl/pipe_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_mdu_ctrl
//  Description : Iterative multiply/divide sequencer with HI/LO registers.
//                It sits beside the EXE stage and takes mult/multu/div/divu
//                from ID. Multiply uses a radix-2 shift-add loop and divide
//                uses a restoring-subtract loop. Each op runs for WIDTH
//                iterations and is followed by one sign-fix cycle. The
//                stall output holds an HI/LO consumer in ID until the
//                result has been written.
//  Ports       : clk       - clock, all state on rising edge
//                clrn      - asynchronous active-low reset
//                start     - launch op with a/b (sampled in IDLE only)
//                op        - 00 mult, 01 multu, 10 div, 11 divu
//                a, b      - rs / rt operands
//                cancel    - flush: abort op, no HI/LO update
//                use_hilo  - ID instruction depends on HI/LO
//                whi, wlo  - mthi / mtlo write strobes (IDLE only)
//                wdata     - mthi / mtlo data
//                busy      - sequencer not idle
//                done      - one-cycle pulse after HI/LO written by an op
//                stall     - busy & use_hilo
//                hi, lo    - HI / LO architectural registers
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             use_hilo,
    input  logic             whi,
    input  logic             wlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            C_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    // acc: product upper half / partial remainder
    // sh : multiplier then product lower half / dividend then quotient
    // opnd: multiplicand (mult) or divisor (div), magnitudes for signed ops
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     araw_q, araw_d;
    logic                 sgn_a_q, sgn_a_d;
    logic                 sgn_b_q, sgn_b_d;
    logic                 is_div_q, is_div_d;
    logic                 bzero_q, bzero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    // Operand magnitudes; unsigned ops never see a sign.
    logic                 w_sign_a, w_sign_b;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b;

    assign w_sign_a = ~op[0] & a[WIDTH-1];
    assign w_sign_b = ~op[0] & b[WIDTH-1];
    assign w_abs_a  = w_sign_a ? -a : a;
    assign w_abs_b  = w_sign_b ? -b : b;

    // Multiply step: the carry out of the add becomes the new MSB after
    // the right shift, so the sum is kept WIDTH+1 bits wide.
    logic [WIDTH:0]       w_mul_sum;
    assign w_mul_sum = {1'b0, acc_q} + {1'b0, (sh_q[0] ? opnd_q : '0)};

    // Divide step: the shifted remainder can reach WIDTH+1 bits, and one
    // more bit holds the borrow of the trial subtraction.
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH+1:0]     w_trial;
    logic                 w_borrow;
    logic                 w_unused_trial_msb;

    assign w_rem_sh           = {acc_q, sh_q[WIDTH-1]};
    assign w_trial            = {1'b0, w_rem_sh} - {2'b00, opnd_q};
    assign w_borrow           = w_trial[WIDTH+1];
    // A successful trial is below the divisor, so this bit is always 0.
    assign w_unused_trial_msb = w_trial[WIDTH];

    // Sign correction applied in the FIX cycle.
    logic [2*WIDTH-1:0]   w_prod_neg;
    logic [WIDTH-1:0]     w_fix_hi, w_fix_lo;

    assign w_prod_neg = -{acc_q, sh_q};

    always_comb begin
        w_fix_hi = acc_q;
        w_fix_lo = sh_q;
        if (!is_div_q) begin
            if (sgn_a_q ^ sgn_b_q) begin
                {w_fix_hi, w_fix_lo} = w_prod_neg;
            end
        end else if (bzero_q) begin
            // Divide by zero: the loop result is ignored.
            w_fix_hi = araw_q;
            w_fix_lo = '1;
        end else begin
            if (sgn_a_q ^ sgn_b_q) begin
                w_fix_lo = -sh_q;
            end
            if (sgn_a_q) begin
                w_fix_hi = -acc_q;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        opnd_d   = opnd_q;
        araw_d   = araw_q;
        sgn_a_d  = sgn_a_q;
        sgn_b_d  = sgn_b_q;
        is_div_d = is_div_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!cancel) begin
                    if (whi) begin
                        hi_d = wdata;
                    end
                    if (wlo) begin
                        lo_d = wdata;
                    end
                    if (start) begin
                        state_d  = S_CALC;
                        cnt_d    = C_CNT_INIT;
                        acc_d    = '0;
                        araw_d   = a;
                        sgn_a_d  = w_sign_a;
                        sgn_b_d  = w_sign_b;
                        is_div_d = op[1];
                        bzero_d  = (b == '0);
                        if (op[1]) begin
                            sh_d   = w_abs_a;
                            opnd_d = w_abs_b;
                        end else begin
                            sh_d   = w_abs_b;
                            opnd_d = w_abs_a;
                        end
                    end
                end
            end

            S_CALC: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = w_borrow ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                        sh_d  = {sh_q[WIDTH-2:0], ~w_borrow};
                    end else begin
                        acc_d = w_mul_sum[WIDTH:1];
                        sh_d  = {w_mul_sum[0], sh_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - C_CNT_ONE;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    hi_d   = w_fix_hi;
                    lo_d   = w_fix_lo;
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opnd_q   <= '0;
            araw_q   <= '0;
            sgn_a_q  <= 1'b0;
            sgn_b_q  <= 1'b0;
            is_div_q <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opnd_q   <= opnd_d;
            araw_q   <= araw_d;
            sgn_a_q  <= sgn_a_d;
            sgn_b_q  <= sgn_b_d;
            is_div_q <= is_div_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign stall = busy & use_hilo;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_mdu_ctrl
//  Description : Self-checking bench for pipe_mdu_ctrl. A table of directed
//                mult/div vectors with hand-computed HI/LO plus timing
//                checks, followed by sequences for cancel, async reset,
//                mthi/mtlo, start-with-write and stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mdu_ctrl;

    logic        clk;
    logic        clrn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        use_hilo;
    logic        whi;
    logic        wlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    pipe_mdu_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .use_hilo (use_hilo),
        .whi      (whi),
        .wlo      (wlo),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Launches an op (edge N is the first posedge after start is driven)
    // and observes cycles N+1..N+40 at the falling edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int busy_cnt, output int done_at, output int done_cnt,
                          output int overlap);
        busy_cnt = 0;
        done_at  = 0;
        done_cnt = 0;
        overlap  = 0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            if (j > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = j;
            end
            if (busy && done) overlap++;
        end
    endtask

    initial begin
        int bc, da, dc, ov;
        int st_cnt;
        int st_first_low;

        clrn     = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        a        = '0;
        b        = '0;
        cancel   = 1'b0;
        use_hilo = 1'b0;
        whi      = 1'b0;
        wlo      = 1'b0;
        wdata    = '0;

        //             op     a             b             hi            lo
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[6]  = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9]  = '{2'b00, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
        vecs[10] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        chk("reset_busy",  busy,  0);
        chk("reset_done",  done,  0);
        chk("reset_stall", stall, 0);
        chk("reset_hi",    hi,    0);
        chk("reset_lo",    lo,    0);

        // ---------------- mthi / mtlo ----------------
        whi = 1'b1; wdata = 32'h5A;
        @(negedge clk);
        whi = 1'b0;
        chk("mthi_hi", hi, 32'h5A);
        chk("mthi_lo_kept", lo, 0);
        whi = 1'b1; wdata = 32'h11;
        @(negedge clk);
        whi = 1'b0; wlo = 1'b1; wdata = 32'h22;
        @(negedge clk);
        wlo = 1'b0;
        chk("mtlo_lo", lo, 32'h22);
        chk("mtlo_hi_kept", hi, 32'h11);

        // ---------------- cancel at N+10 ----------------
        dc = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            if (j > 1) @(negedge clk);
            if (j == 1) chk("cancel_busy_n1", busy, 1);
            if (j == 10) cancel = 1'b1;
            if (j == 11) begin
                cancel = 1'b0;
                chk("cancel_busy_n11", busy, 0);
            end
            if (done) dc++;
        end
        chk("cancel_no_done", dc, 0);
        chk("cancel_hi", hi, 32'h11);
        chk("cancel_lo", lo, 32'h22);

        // ---------------- async reset at N+5 ----------------
        dc = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            if (j > 1) @(negedge clk);
            if (j == 5) begin
                clrn = 1'b0;
                #1;
                chk("clrn_hi_now",   hi,   0);
                chk("clrn_lo_now",   lo,   0);
                chk("clrn_busy_now", busy, 0);
                #2;
                clrn = 1'b1;
            end
            if (done) dc++;
        end
        chk("clrn_no_done", dc, 0);
        chk("clrn_lo_after", lo, 0);

        // ---------------- table vectors ----------------
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc, da, dc, ov);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("vec%0d_busy_cycles", i), bc, 33);
            chk($sformatf("vec%0d_done_cycle", i), da, 34);
            chk($sformatf("vec%0d_done_count", i), dc, 1);
            chk($sformatf("vec%0d_busy_done_overlap", i), ov, 0);
        end

        // ---------------- start with mthi; writes while busy ignored ----------------
        dc = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
        whi = 1'b1; wdata = 32'hAB;
        @(negedge clk);
        start = 1'b0; whi = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            if (j > 1) @(negedge clk);
            if (j == 1) chk("startwhi_hi_early", hi, 32'hAB);
            if (j == 5) begin
                start = 1'b1; a = 32'd9; b = 32'd9;
                whi = 1'b1; wlo = 1'b1; wdata = 32'hDEAD;
            end
            if (j == 6) begin
                start = 1'b0; whi = 1'b0; wlo = 1'b0;
            end
            if (done) dc++;
        end
        chk("startwhi_hi_final", hi, 0);
        chk("startwhi_lo_final", lo, 6);
        chk("startwhi_done_count", dc, 1);

        // ---------------- stall ----------------
        use_hilo = 1'b1;
        @(negedge clk);
        chk("stall_idle", stall, 0);
        st_cnt       = 0;
        st_first_low = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            if (j > 1) @(negedge clk);
            if (stall) st_cnt++;
            else if (st_first_low == 0) st_first_low = j;
        end
        use_hilo = 1'b0;
        chk("stall_cycles", st_cnt, 33);
        chk("stall_first_low", st_first_low, 34);
        chk("stall_div_lo", lo, 10);
        chk("stall_div_hi", hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
